// File: rtl/player_hp_bank.sv
// Multi-player HP bank with iframes, KO latching and round winner/draw arbitration.
// Optional HP_REGEN_EN macro adds a per-player periodic +1 HP regeneration.
module player_hp_bank #(
    parameter int unsigned N_PLAYERS    = 2,
    parameter int unsigned MAX_HP       = 100,
    parameter int unsigned HP_WIDTH     = 7,
    parameter int unsigned DMG_WIDTH    = 7,
    parameter int unsigned IFRAMES      = 8,
    parameter int unsigned REGEN_PERIOD = 60
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           SCEN,
    input  logic                           round_start,
    input  logic [N_PLAYERS-1:0]           hit_valid,
    input  logic [N_PLAYERS*DMG_WIDTH-1:0] hit_damage,
    input  logic [N_PLAYERS-1:0]           heal_valid,
    input  logic [N_PLAYERS*DMG_WIDTH-1:0] heal_amount,
    output logic [N_PLAYERS*HP_WIDTH-1:0]  hp,
    output logic [N_PLAYERS-1:0]           invuln,
    output logic [N_PLAYERS-1:0]           ko,
    output logic [N_PLAYERS-1:0]           ko_pulse,
    output logic                           round_over,
    output logic                           round_over_pulse,
    output logic [2:0]                     winner,
    output logic                           draw
);
    localparam int unsigned SUM_W = ((HP_WIDTH > DMG_WIDTH) ? HP_WIDTH : DMG_WIDTH) + 2;
    localparam int unsigned IF_W  = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
    localparam int unsigned CNT_W = 4;

    if (N_PLAYERS < 2 || N_PLAYERS > 8 || MAX_HP >= (1 << HP_WIDTH) || REGEN_PERIOD == 0) begin : g_bad_cfg
        $error("player_hp_bank: illegal parameter combination");
    end

    typedef enum logic {FIGHT = 1'b0, OVER = 1'b1} state_t;

    state_t                        state_q, state_d;
    logic [IF_W-1:0]               ifr_q [N_PLAYERS];
    logic [IF_W-1:0]               ifr_d [N_PLAYERS];
    logic [N_PLAYERS*HP_WIDTH-1:0] hp_d;
    logic [N_PLAYERS-1:0]          invuln_d, ko_d, ko_pulse_d;
    logic                          round_over_d, round_over_pulse_d, draw_d;
    logic [2:0]                    winner_d;

    logic signed [SUM_W-1:0]       sum, dmg_ext, heal_ext, regen_ext;
    logic                          eff_hit, lethal;
    logic [CNT_W-1:0]              alive_cnt;

`ifdef HP_REGEN_EN
    localparam int unsigned RG_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    logic [RG_W-1:0]               regen_q [N_PLAYERS];
    logic [RG_W-1:0]               regen_d [N_PLAYERS];
`endif

    // Next-state for the round FSM and every per-player register
    always_comb begin
        state_d            = state_q;
        hp_d               = hp;
        invuln_d           = invuln;
        ko_d               = ko;
        ko_pulse_d         = '0;
        round_over_d       = round_over;
        round_over_pulse_d = 1'b0;
        winner_d           = winner;
        draw_d             = draw;
        sum                = '0;
        dmg_ext            = '0;
        heal_ext           = '0;
        regen_ext          = '0;
        eff_hit            = 1'b0;
        lethal             = 1'b0;
        alive_cnt          = '0;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
            ifr_d[i] = ifr_q[i];
`ifdef HP_REGEN_EN
            regen_d[i] = regen_q[i];
`endif
        end

        if (SCEN && round_start) begin
            state_d      = FIGHT;
            ko_d         = '0;
            invuln_d     = '0;
            round_over_d = 1'b0;
            winner_d     = '0;
            draw_d       = 1'b0;
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                hp_d[i*HP_WIDTH +: HP_WIDTH] = HP_WIDTH'(MAX_HP);
                ifr_d[i] = '0;
`ifdef HP_REGEN_EN
                regen_d[i] = '0;
`endif
            end
        end else if (SCEN) begin
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                if (ifr_q[i] != '0) begin
                    ifr_d[i] = ifr_q[i] - IF_W'(1);
                end
                if (state_q == FIGHT && !ko[i]) begin
                    eff_hit   = hit_valid[i] && (hit_damage[i*DMG_WIDTH +: DMG_WIDTH] != '0)
                                && (ifr_q[i] == '0);
                    dmg_ext   = eff_hit ? SUM_W'(hit_damage[i*DMG_WIDTH +: DMG_WIDTH]) : '0;
                    heal_ext  = heal_valid[i] ? SUM_W'(heal_amount[i*DMG_WIDTH +: DMG_WIDTH]) : '0;
                    regen_ext = '0;
`ifdef HP_REGEN_EN
                    // Regen counter idles at full HP and restarts after any landed hit
                    if (hp[i*HP_WIDTH +: HP_WIDTH] == HP_WIDTH'(MAX_HP)) begin
                        regen_d[i] = '0;
                    end else if (regen_q[i] == RG_W'(REGEN_PERIOD - 1)) begin
                        regen_d[i] = '0;
                        regen_ext  = SUM_W'(1);
                    end else begin
                        regen_d[i] = regen_q[i] + RG_W'(1);
                    end
                    if (eff_hit) begin
                        regen_d[i] = '0;
                    end
`endif
                    sum    = SUM_W'(hp[i*HP_WIDTH +: HP_WIDTH]) - dmg_ext + heal_ext + regen_ext;
                    lethal = sum[SUM_W-1] || (sum == '0);
                    if (lethal) begin
                        hp_d[i*HP_WIDTH +: HP_WIDTH] = '0;
                        ko_d[i]       = 1'b1;
                        ko_pulse_d[i] = 1'b1;
                        ifr_d[i]      = '0;
`ifdef HP_REGEN_EN
                        regen_d[i]    = '0;
`endif
                    end else begin
                        if (sum > $signed(SUM_W'(MAX_HP))) begin
                            hp_d[i*HP_WIDTH +: HP_WIDTH] = HP_WIDTH'(MAX_HP);
                        end else begin
                            hp_d[i*HP_WIDTH +: HP_WIDTH] = HP_WIDTH'(sum);
                        end
                        if (eff_hit) begin
                            ifr_d[i] = IF_W'(IFRAMES);
                        end
                    end
                end else begin
`ifdef HP_REGEN_EN
                    regen_d[i] = '0;
`endif
                end
                invuln_d[i] = (ifr_d[i] != '0);
            end

            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                alive_cnt = alive_cnt + CNT_W'(!ko_d[i]);
            end
            // Round ends on the same tick as the KO that leaves at most one survivor
            if (state_q == FIGHT && alive_cnt <= CNT_W'(1)) begin
                state_d            = OVER;
                round_over_d       = 1'b1;
                round_over_pulse_d = 1'b1;
                draw_d             = (alive_cnt == '0);
                winner_d           = '0;
                for (int i = 0; i < int'(N_PLAYERS); i++) begin
                    if (!ko_d[i]) begin
                        winner_d = 3'(i);
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= FIGHT;
            hp               <= {N_PLAYERS{HP_WIDTH'(MAX_HP)}};
            invuln           <= '0;
            ko               <= '0;
            ko_pulse         <= '0;
            round_over       <= 1'b0;
            round_over_pulse <= 1'b0;
            winner           <= '0;
            draw             <= 1'b0;
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                ifr_q[i] <= '0;
`ifdef HP_REGEN_EN
                regen_q[i] <= '0;
`endif
            end
        end else begin
            state_q          <= state_d;
            hp               <= hp_d;
            invuln           <= invuln_d;
            ko               <= ko_d;
            ko_pulse         <= ko_pulse_d;
            round_over       <= round_over_d;
            round_over_pulse <= round_over_pulse_d;
            winner           <= winner_d;
            draw             <= draw_d;
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                ifr_q[i] <= ifr_d[i];
`ifdef HP_REGEN_EN
                regen_q[i] <= regen_d[i];
`endif
            end
        end
    end

endmodule
